// File: rtl/bcd_pkg.sv
// Shared BCD types, constants and conversion helpers for the BCD counter.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX_DIGIT  = 4'd9;
  localparam int         BCD_MAX_DIGITS = 4;

  // Converts a non-negative integer into packed BCD, digit 0 in [3:0].
  // Used at elaboration time to turn the MAX_VAL parameter into a BCD limit.
  function automatic logic [4*BCD_MAX_DIGITS-1:0] int_to_bcd(input int value);
    logic [4*BCD_MAX_DIGITS-1:0] result;
    int                          rem;
    result = '0;
    rem    = value;
    for (int i = 0; i < BCD_MAX_DIGITS; i++) begin
      result[4*i +: 4] = 4'(rem % 10);
      rem              = rem / 10;
    end
    return result;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD decade: increments or decrements its digit when the carry/borrow
// input is set and reports a carry/borrow out when it rolls over (9->0 or 0->9).
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_up,
  input  logic       i_cin,
  output logic [3:0] o_digit,
  output logic       o_cout
);

  // Decade step with decimal rollover; holds the digit when no carry arrives.
  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    o_digit = i_digit;
    o_cout  = 1'b0;
    if (i_cin) begin
      if (i_up) begin
        if (i_digit >= BCD_MAX_DIGIT) begin
          o_digit = '0;
          o_cout  = 1'b1;
        end else begin
          o_digit = i_digit + 4'd1;
        end
      end else begin
        if (i_digit == '0) begin
          o_digit = BCD_MAX_DIGIT;
          o_cout  = 1'b1;
        end else begin
          o_digit = i_digit - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-decade BCD up/down counter with run/direction toggles, a free-running
// prescaler that sets the step rate, synchronous load with clamping, and
// at-limit flags. Define BCD_CNT_WRAP_EN to wrap at the limits (with a
// one-cycle wrap pulse) instead of saturating.
module bcd_updown_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS   = 2,
  parameter int MAX_VAL  = 99,
  parameter int TICK_DIV = 25
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_pulse,
  input  logic                  dir_pulse,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  run,
  output logic                  dir,
  output logic                  max,
  output logic                  min,
  output logic                  wrap
);

  localparam int                          W           = 4 * DIGITS;
  localparam logic [4*BCD_MAX_DIGITS-1:0] MAX_BCD_ALL = int_to_bcd(MAX_VAL);
  localparam logic [W-1:0]                MAX_BCD     = MAX_BCD_ALL[W-1:0];

  logic [TICK_DIV-1:0] r_presc;
  logic [W-1:0]        r_bcd;
  logic                r_run;
  logic                r_dir;

  logic                w_tick;
  logic [DIGITS:0]     w_carry;
  logic [W-1:0]        w_stepped;
  logic [W-1:0]        w_load_digits;
  logic [W-1:0]        w_load_clamped;
  logic [W-1:0]        w_next_bcd;
  logic                w_at_max;
  logic                w_at_zero;
  logic                w_unused_carry;

  assign w_tick    = &r_presc;
  assign w_at_max  = (r_bcd == MAX_BCD);
  assign w_at_zero = (r_bcd == '0);

  // The ripple out of the top decade is not needed: limits are detected by
  // comparing against MAX_BCD and zero before stepping.
  assign w_unused_carry = w_carry[DIGITS];

  // Decimal carry/borrow chain; the lowest decade always receives the step.
  assign w_carry[0] = 1'b1;
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_digit_cell u_cell (
      .i_digit (r_bcd[4*g +: 4]),
      .i_up    (r_dir),
      .i_cin   (w_carry[g]),
      .o_digit (w_stepped[4*g +: 4]),
      .o_cout  (w_carry[g+1])
    );
  end

  // Load value sanitising: clamp each digit to 9, then the whole value to MAX_VAL.
  // Valid packed BCD orders the same as its binary reading, so a plain compare works.
  always_comb begin
    w_load_digits = load_val;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > BCD_MAX_DIGIT) begin
        w_load_digits[4*i +: 4] = BCD_MAX_DIGIT;
      end
    end
    w_load_clamped = (w_load_digits > MAX_BCD) ? MAX_BCD : w_load_digits;
  end

  // Next count: load wins, otherwise step on a running tick, handling the limits.
  always_comb begin
    w_next_bcd = r_bcd;
    if (load) begin
      w_next_bcd = w_load_clamped;
    end else if (w_tick && r_run) begin
      if (r_dir) begin
        if (w_at_max) begin
`ifdef BCD_CNT_WRAP_EN
          w_next_bcd = '0;
`else
          w_next_bcd = r_bcd;
`endif
        end else begin
          w_next_bcd = w_stepped;
        end
      end else begin
        if (w_at_zero) begin
`ifdef BCD_CNT_WRAP_EN
          w_next_bcd = MAX_BCD;
`else
          w_next_bcd = r_bcd;
`endif
        end else begin
          w_next_bcd = w_stepped;
        end
      end
    end
  end

  // Prescaler, count and run/direction state; toggles use the pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc <= '0;
      r_bcd   <= '0;
      r_run   <= 1'b0;
      r_dir   <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values of the others.
      r_presc <= r_presc + TICK_DIV'(1);
      r_bcd   <= w_next_bcd;
      if (en_pulse)  r_run <= ~r_run;
      if (dir_pulse) r_dir <= ~r_dir;
    end
  end

`ifdef BCD_CNT_WRAP_EN
  logic r_wrap;
  logic w_next_wrap;

  // Wrap fires only on a running tick at the limit in the current direction.
  always_comb begin
    w_next_wrap = 1'b0;
    if (!load && w_tick && r_run) begin
      w_next_wrap = r_dir ? w_at_max : w_at_zero;
    end
  end

  // One-cycle wrap pulse, aligned with the wrapped count value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_next_wrap;
    end
  end

  assign wrap = r_wrap;
`else
  assign wrap = 1'b0;
`endif

  assign bcd = r_bcd;
  assign run = r_run;
  assign dir = r_dir;
  assign max = w_at_max & r_dir;
  assign min = w_at_zero & ~r_dir;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed testbench for bcd_updown_counter (DIGITS=2, TICK_DIV=2). A second
// instance with MAX_VAL=40 shares the inputs to cover load clamping to MAX_VAL.
// Expected values follow BCD_CNT_WRAP_EN when it is defined.
module tb_bcd_updown_counter;

  localparam int DIGITS   = 2;
  localparam int TICK_DIV = 2;

  logic       clk       = 1'b0;
  logic       rst       = 1'b0;
  logic       en_pulse  = 1'b0;
  logic       dir_pulse = 1'b0;
  logic       load      = 1'b0;
  logic [7:0] load_val  = '0;

  logic [7:0] bcd, bcd40;
  logic       run, dir, max, min, wrap;
  logic       run40, dir40, max40, min40, wrap40;

  int n_tests = 0;
  int n_fail  = 0;

  bcd_updown_counter #(.DIGITS(DIGITS), .MAX_VAL(99), .TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .rst(rst), .en_pulse(en_pulse), .dir_pulse(dir_pulse),
    .load(load), .load_val(load_val), .bcd(bcd), .run(run), .dir(dir),
    .max(max), .min(min), .wrap(wrap)
  );

  bcd_updown_counter #(.DIGITS(DIGITS), .MAX_VAL(40), .TICK_DIV(TICK_DIV)) dut40 (
    .clk(clk), .rst(rst), .en_pulse(en_pulse), .dir_pulse(dir_pulse),
    .load(load), .load_val(load_val), .bcd(bcd40), .run(run40), .dir(dir40),
    .max(max40), .min(min40), .wrap(wrap40)
  );

  always #5 clk = ~clk;

  // Reference prescaler phase: a tick cycle is one where this reads 3.
  logic [1:0] tb_presc = '0;
  always @(posedge clk or negedge rst) begin
    if (!rst) tb_presc <= '0;
    else      tb_presc <= tb_presc + 2'd1;
  end

  typedef struct {
    string      name;
    logic       en;
    logic       dp;
    logic       ld;
    logic [7:0] val;
    int         ticks;
    logic [7:0] e_bcd;
    logic       e_run;
    logic       e_dir;
    logic       e_max;
    logic       e_min;
    logic       e_wrap;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Advance until one count step has been applied (ends just after the step edge).
  task automatic tick_step();
    for (int k = 0; k < 8 && tb_presc != 2'd3; k++) cycle();
    cycle();
  endtask

  task automatic add_vec(input string name, input logic en, input logic dp, input logic ld,
                         input logic [7:0] val, input int ticks, input logic [7:0] e_bcd,
                         input logic e_run, input logic e_dir, input logic e_max,
                         input logic e_min, input logic e_wrap);
    vec_t v;
    v.name = name; v.en = en; v.dp = dp; v.ld = ld; v.val = val; v.ticks = ticks;
    v.e_bcd = e_bcd; v.e_run = e_run; v.e_dir = e_dir;
    v.e_max = e_max; v.e_min = e_min; v.e_wrap = e_wrap;
    vecs.push_back(v);
  endtask

  task automatic apply_vec(input vec_t v);
    for (int k = 0; k < 4 && tb_presc == 2'd3; k++) cycle();
    en_pulse  = v.en;
    dir_pulse = v.dp;
    load      = v.ld;
    load_val  = v.val;
    cycle();
    en_pulse  = 1'b0;
    dir_pulse = 1'b0;
    load      = 1'b0;
    load_val  = '0;
    for (int t = 0; t < v.ticks; t++) tick_step();
    check({v.name, ".bcd"},  bcd,  v.e_bcd);
    check({v.name, ".run"},  run,  v.e_run);
    check({v.name, ".dir"},  dir,  v.e_dir);
    check({v.name, ".max"},  max,  v.e_max);
    check({v.name, ".min"},  min,  v.e_min);
    check({v.name, ".wrap"}, wrap, v.e_wrap);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //      name         en dp ld val    tk  bcd    run dir max min wrap
    add_vec("count10",   1, 0, 0, 8'h00, 10, 8'h10, 1,  1,  0,  0,  0);
    add_vec("load97",    0, 0, 1, 8'h97, 0,  8'h97, 1,  1,  0,  0,  0);
    add_vec("up98",      0, 0, 0, 8'h00, 1,  8'h98, 1,  1,  0,  0,  0);
    add_vec("up99",      0, 0, 0, 8'h00, 1,  8'h99, 1,  1,  1,  0,  0);
`ifdef BCD_CNT_WRAP_EN
    add_vec("up_lim1",   0, 0, 0, 8'h00, 1,  8'h00, 1,  1,  0,  0,  1);
    add_vec("up_lim2",   0, 0, 0, 8'h00, 1,  8'h01, 1,  1,  0,  0,  0);
`else
    add_vec("up_lim1",   0, 0, 0, 8'h00, 1,  8'h99, 1,  1,  1,  0,  0);
    add_vec("up_lim2",   0, 0, 0, 8'h00, 1,  8'h99, 1,  1,  1,  0,  0);
`endif
    add_vec("load02_dn", 0, 1, 1, 8'h02, 0,  8'h02, 1,  0,  0,  0,  0);
    add_vec("dn01",      0, 0, 0, 8'h00, 1,  8'h01, 1,  0,  0,  0,  0);
    add_vec("dn00",      0, 0, 0, 8'h00, 1,  8'h00, 1,  0,  0,  1,  0);
`ifdef BCD_CNT_WRAP_EN
    add_vec("dn_lim",    0, 0, 0, 8'h00, 1,  8'h99, 1,  0,  0,  0,  1);
`else
    add_vec("dn_lim",    0, 0, 0, 8'h00, 1,  8'h00, 1,  0,  0,  1,  0);
`endif
    add_vec("load05_up", 0, 1, 1, 8'h05, 0,  8'h05, 1,  1,  0,  0,  0);

    // Reset state while rst is held low.
    for (int k = 0; k < 3; k++) cycle();
    check("rst.bcd",  bcd,  8'h00);
    check("rst.run",  run,  1'b0);
    check("rst.dir",  dir,  1'b1);
    check("rst.max",  max,  1'b0);
    check("rst.min",  min,  1'b0);
    check("rst.wrap", wrap, 1'b0);
    rst = 1'b1;

    foreach (vecs[i]) apply_vec(vecs[i]);

    // en_pulse on a tick cycle: the step uses the old run=1, then counting stops.
    for (int k = 0; k < 8 && tb_presc != 2'd3; k++) cycle();
    en_pulse = 1'b1;
    cycle();
    en_pulse = 1'b0;
    check("en_tick.bcd", bcd, 8'h06);
    check("en_tick.run", run, 1'b0);
    tick_step();
    tick_step();
    check("en_tick.hold", bcd, 8'h06);

    // Load clamping: per-digit to 9, then to MAX_VAL.
    load = 1'b1; load_val = 8'hAF;
    cycle();
    load = 1'b0;
    check("clampAF.bcd",   bcd,   8'h99);
    check("clampAF.max",   max,   1'b1);
    check("clampAF.bcd40", bcd40, 8'h40);
    check("clampAF.max40", max40, 1'b1);
    load = 1'b1; load_val = 8'h42;
    cycle();
    load = 1'b0;
    check("clamp42.bcd",   bcd,   8'h42);
    check("clamp42.bcd40", bcd40, 8'h40);

    // Reset asserted mid-count acts before the next clock edge.
    en_pulse = 1'b1; dir_pulse = 1'b1; load = 1'b1; load_val = 8'h57;
    cycle();
    en_pulse = 1'b0; dir_pulse = 1'b0; load = 1'b0; load_val = '0;
    check("pre_rst.bcd", bcd, 8'h57);
    check("pre_rst.run", run, 1'b1);
    check("pre_rst.dir", dir, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst.bcd",  bcd,  8'h00);
    check("async_rst.run",  run,  1'b0);
    check("async_rst.dir",  dir,  1'b1);
    check("async_rst.max",  max,  1'b0);
    check("async_rst.min",  min,  1'b0);
    check("async_rst.wrap", wrap, 1'b0);
    for (int k = 0; k < 3; k++) cycle();
    check("rst_hold.bcd", bcd, 8'h00);
    check("rst_hold.run", run, 1'b0);

    // After release, the first step lands 2^TICK_DIV clocks later.
    rst = 1'b1;
    en_pulse = 1'b1;
    cycle();
    en_pulse = 1'b0;
    cycle();
    cycle();
    check("restart.pre_tick", bcd, 8'h00);
    check("restart.run",      run, 1'b1);
    cycle();
    check("restart.first_step", bcd, 8'h01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
